semaforo_fsm: RTL and testbench

Clocked, parametrised successor to the combinational N_S/L_O traffic-light decoder. Drives full red/yellow/green heads for two crossing directions, North-South (NS) and East-West (LO). Sensor-driven green arbitration uses minimum and maximum green times, a fixed yellow time and an all-red clearance time. Adds a night mode in which both yellow lamps flash. Sits between the vehicle-sensor inputs and the lamp drivers of the crossing.

---
 rtl/semaforo_pkg.sv | 20 ++
 rtl/semaforo_timer.sv | 36 +++
 rtl/semaforo_fsm.sv | 106 ++++++++++
 tb/tb_semaforo_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and lamp constants for the clocked NS/LO traffic-light controller.
package semaforo_pkg;

    typedef enum logic [2:0] {
        NS_VERDE = 3'd0,
        NS_AMAR  = 3'd1,
        VERM_A   = 3'd2,
        LO_VERDE = 3'd3,
        LO_AMAR  = 3'd4,
        VERM_B   = 3'd5,
        PISCA    = 3'd6
    } state_t;

    // Lamp heads are {red, yellow, green}.
    localparam logic [2:0] VERMELHO = 3'b100;
    localparam logic [2:0] AMARELO  = 3'b010;
    localparam logic [2:0] VERDE    = 3'b001;
    localparam logic [2:0] APAGADO  = 3'b000;

endpackage

// File: rtl/semaforo_timer.sv
// Dwell counter: clear wins, otherwise counts up, holding or wrapping once it reaches lim.
module semaforo_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         sat,
    input  logic         wrap,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt + W'(1);
        if (clr) begin
            cnt_nxt = '0;
        end else if (cnt >= lim) begin
            if (wrap) begin
                cnt_nxt = '0;
            end else if (sat) begin
                cnt_nxt = cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/semaforo_fsm.sv
// Sensor-arbitrated two-way traffic-light controller with yellow, all-red clearance and night flashing.
module semaforo_fsm #(
    parameter int unsigned N_SENS      = 2,
    parameter int unsigned T_GREEN_MIN = 8,
    parameter int unsigned T_GREEN_MAX = 20,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALL_RED   = 2,
    parameter int unsigned T_BLINK     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] sens_ns,
    input  logic [N_SENS-1:0] sens_lo,
    input  logic              noturno,
    output logic [2:0]        luz_ns,
    output logic [2:0]        luz_lo,
    output logic              N_S,
    output logic              L_O,
    output logic [2:0]        estado
);
    import semaforo_pkg::*;

    if (T_GREEN_MIN < 1 || T_GREEN_MAX < 1 || T_YELLOW < 1 || T_ALL_RED < 1 || T_BLINK < 1
        || T_GREEN_MAX < T_GREEN_MIN) begin : g_bad_params
        $error("semaforo_fsm: illegal timing parameters");
    end

    localparam int unsigned D_A   = (T_GREEN_MAX > T_YELLOW) ? T_GREEN_MAX : T_YELLOW;
    localparam int unsigned D_B   = (T_ALL_RED > 2 * T_BLINK) ? T_ALL_RED : 2 * T_BLINK;
    localparam int unsigned D_MAX = (D_A > D_B) ? D_A : D_B;
    localparam int unsigned W     = $clog2(D_MAX) + 1;

    localparam logic [W-1:0] C_GMIN   = W'(T_GREEN_MIN - 1);
    localparam logic [W-1:0] C_GMAX   = W'(T_GREEN_MAX - 1);
    localparam logic [W-1:0] C_Y      = W'(T_YELLOW - 1);
    localparam logic [W-1:0] C_R      = W'(T_ALL_RED - 1);
    localparam logic [W-1:0] C_BLINK  = W'(T_BLINK);
    localparam logic [W-1:0] C_BLINK2 = W'(2 * T_BLINK - 1);

    state_t       state, nxt;
    logic [W-1:0] cnt, cnt_nxt, lim;
    logic         dem_ns, dem_lo, mn, mx, clr, sat, wrap;

    assign dem_ns = |sens_ns;
    assign dem_lo = |sens_lo;
    assign mn     = (cnt >= C_GMIN);
    assign mx     = (cnt >= C_GMAX);

    always_comb begin
        nxt = state;
        case (state)
            NS_VERDE: if (mn && (noturno || (dem_lo && (!dem_ns || mx)))) nxt = NS_AMAR;
            LO_VERDE: if (mn && (noturno || (dem_ns && (!dem_lo || mx)))) nxt = LO_AMAR;
            NS_AMAR:  if (cnt == C_Y) nxt = VERM_A;
            LO_AMAR:  if (cnt == C_Y) nxt = VERM_B;
            VERM_A:   if (cnt == C_R) nxt = noturno ? PISCA : LO_VERDE;
            VERM_B:   if (cnt == C_R) nxt = noturno ? PISCA : NS_VERDE;
            PISCA:    if (!noturno) nxt = VERM_B;
            default:  nxt = VERM_B;
        endcase
    end

    assign clr  = (nxt != state);
    assign sat  = (state == NS_VERDE) || (state == LO_VERDE);
    assign wrap = (state == PISCA);
    assign lim  = sat ? C_GMAX : C_BLINK2;

    semaforo_timer #(.W(W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .sat     (sat),
        .wrap    (wrap),
        .lim     (lim),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt)
    );

    function automatic logic [5:0] decode(input state_t s, input logic blink_on);
        case (s)
            NS_VERDE: return {VERDE, VERMELHO};
            NS_AMAR:  return {AMARELO, VERMELHO};
            LO_VERDE: return {VERMELHO, VERDE};
            LO_AMAR:  return {VERMELHO, AMARELO};
            PISCA:    return blink_on ? {AMARELO, AMARELO} : {APAGADO, APAGADO};
            default:  return {VERMELHO, VERMELHO};
        endcase
    endfunction

    // Lamps are decoded from the next state/count so they register alongside state and cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= VERM_B;
            luz_ns <= VERMELHO;
            luz_lo <= VERMELHO;
        end else begin
            state            <= nxt;
            {luz_ns, luz_lo} <= decode(nxt, cnt_nxt < C_BLINK);
        end
    end

    assign N_S    = luz_ns[0];
    assign L_O    = luz_lo[0];
    assign estado = state;

endmodule

// File: tb/tb_semaforo_fsm.sv
// Bench for semaforo_fsm: phase-level reference model, directed lamp sequences, random safety run.
module tb_semaforo_fsm;
    import semaforo_pkg::*;

    localparam int TGMIN = 8;
    localparam int TGMAX = 20;
    localparam int TY    = 3;
    localparam int TR    = 2;
    localparam int TB    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sens_ns, sens_lo;
    logic       noturno;
    logic [2:0] luz_ns, luz_lo, estado;
    logic       N_S, L_O;

    logic       rst2_n;
    logic [1:0] sens_ns2, sens_lo2;
    logic       noturno2;
    logic [2:0] luz_ns2, luz_lo2, estado2;
    logic       N_S2, L_O2;

    int  checks = 0;
    int  errors = 0;
    bit  rnd_done = 1'b0;

    always #5 clk = ~clk;

    semaforo_fsm dut (
        .clk(clk), .rst_n(rst_n), .sens_ns(sens_ns), .sens_lo(sens_lo), .noturno(noturno),
        .luz_ns(luz_ns), .luz_lo(luz_lo), .N_S(N_S), .L_O(L_O), .estado(estado)
    );

    semaforo_fsm #(.T_GREEN_MIN(2), .T_GREEN_MAX(5)) dut_rnd (
        .clk(clk), .rst_n(rst2_n), .sens_ns(sens_ns2), .sens_lo(sens_lo2), .noturno(noturno2),
        .luz_ns(luz_ns2), .luz_lo(luz_lo2), .N_S(N_S2), .L_O(L_O2), .estado(estado2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase kind, which side it concerns, and cycles elapsed in the phase.
    typedef enum {PH_GREEN, PH_YEL, PH_RED, PH_NIGHT} ph_t;
    ph_t m_ph;
    bit  m_dir;   // green/yellow: side showing it; all-red: side that goes green next
    int  m_t;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit own, other;
        own   = m_dir ? (|sens_lo) : (|sens_ns);
        other = m_dir ? (|sens_ns) : (|sens_lo);
        if (!rst_n) begin
            m_ph <= PH_RED; m_dir <= 1'b0; m_t <= 0; m_valid <= 1'b1;
        end else begin
            case (m_ph)
                PH_GREEN:
                    if ((m_t + 1 >= TGMIN) && (noturno || (other && (!own || m_t + 1 >= TGMAX)))) begin
                        m_ph <= PH_YEL; m_t <= 0;
                    end else m_t <= m_t + 1;
                PH_YEL:
                    if (m_t + 1 == TY) begin
                        m_ph <= PH_RED; m_dir <= !m_dir; m_t <= 0;
                    end else m_t <= m_t + 1;
                PH_RED:
                    if (m_t + 1 == TR) begin
                        m_ph <= noturno ? PH_NIGHT : PH_GREEN; m_t <= 0;
                    end else m_t <= m_t + 1;
                default:
                    if (!noturno) begin
                        m_ph <= PH_RED; m_dir <= 1'b0; m_t <= 0;
                    end else m_t <= (m_t + 1) % (2 * TB);
            endcase
        end
    end

    function automatic logic [2:0] exp_head(input bit side);
        case (m_ph)
            PH_GREEN: return (m_dir == side) ? 3'b001 : 3'b100;
            PH_YEL:   return (m_dir == side) ? 3'b010 : 3'b100;
            PH_RED:   return 3'b100;
            default:  return (m_t < TB) ? 3'b010 : 3'b000;
        endcase
    endfunction

    function automatic state_t exp_state();
        case (m_ph)
            PH_GREEN: return m_dir ? LO_VERDE : NS_VERDE;
            PH_YEL:   return m_dir ? LO_AMAR : NS_AMAR;
            PH_RED:   return m_dir ? VERM_A : VERM_B;
            default:  return PISCA;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [2:0] ens, elo;
            ens = exp_head(1'b0);
            elo = exp_head(1'b1);
            check("model_luz_ns", int'(luz_ns), int'(ens));
            check("model_luz_lo", int'(luz_lo), int'(elo));
            check("model_N_S", int'(N_S), int'(ens[0]));
            check("model_L_O", int'(L_O), int'(elo[0]));
            check("model_estado", int'(estado), int'(exp_state()));
        end
    end

    task automatic run(input logic [2:0] ens, input logic [2:0] elo, input int n, input string name);
        repeat (n) begin
            @(negedge clk);
            check({name, "_ns"}, int'(luz_ns), int'(ens));
            check({name, "_lo"}, int'(luz_lo), int'(elo));
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(3'b100, 3'b100, n, "rst");
        check("rst_estado", int'(estado), int'(VERM_B));
        check("rst_N_S", int'(N_S), 0);
        check("rst_L_O", int'(L_O), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sens_ns = 2'b00; sens_lo = 2'b00; noturno = 1'b0;

        // 1: reset and idle NS green
        do_reset(3);
        run(3'b100, 3'b100, 1, "s1_red");
        run(3'b001, 3'b100, 1, "s1_green");
        check("s1_N_S", int'(N_S), 1);
        run(3'b001, 3'b100, 50, "s1_hold");

        // 2: LO demand only
        sens_lo = 2'b01;
        do_reset(1);
        run(3'b100, 3'b100, 1, "s2_red0");
        run(3'b001, 3'b100, 8, "s2_nsg");
        run(3'b010, 3'b100, 3, "s2_nsy");
        run(3'b100, 3'b100, 2, "s2_allred");
        run(3'b100, 3'b001, 30, "s2_log");

        // 3: continuous demand both ways
        sens_ns = 2'b11; sens_lo = 2'b10;
        do_reset(1);
        run(3'b100, 3'b100, 1, "s3_red0");
        for (int c = 0; c < 3; c++) begin
            run(3'b001, 3'b100, 20, "s3_nsg");
            run(3'b010, 3'b100, 3, "s3_nsy");
            run(3'b100, 3'b100, 2, "s3_ra");
            run(3'b100, 3'b001, 20, "s3_log");
            run(3'b100, 3'b010, 3, "s3_loy");
            run(3'b100, 3'b100, 2, "s3_rb");
        end

        // 4: night mode raised at NS green cnt=2
        sens_ns = 2'b00; sens_lo = 2'b00;
        do_reset(1);
        run(3'b100, 3'b100, 1, "s4_red0");
        run(3'b001, 3'b100, 3, "s4_nsg_a");
        noturno = 1'b1;
        run(3'b001, 3'b100, 5, "s4_nsg_b");
        run(3'b010, 3'b100, 3, "s4_nsy");
        run(3'b100, 3'b100, 2, "s4_ra");
        for (int c = 0; c < 2; c++) begin
            run(3'b010, 3'b010, 4, "s4_blink_on");
            run(3'b000, 3'b000, 4, "s4_blink_off");
        end
        check("s4_estado", int'(estado), int'(PISCA));
        noturno = 1'b0;
        run(3'b100, 3'b100, 2, "s4_rb");
        run(3'b001, 3'b100, 1, "s4_nsg_c");

        // 5: reset during LO yellow cnt=1
        sens_ns = 2'b11; sens_lo = 2'b10;
        do_reset(1);
        run(3'b100, 3'b100, 1, "s5_red0");
        run(3'b001, 3'b100, 20, "s5_nsg");
        run(3'b010, 3'b100, 3, "s5_nsy");
        run(3'b100, 3'b100, 2, "s5_ra");
        run(3'b100, 3'b001, 20, "s5_log");
        run(3'b100, 3'b010, 2, "s5_loy");
        check("s5_estado_loy", int'(estado), int'(LO_AMAR));
        sens_ns = 2'b00; sens_lo = 2'b00;
        do_reset(1);
        run(3'b100, 3'b100, 1, "s5_red1");
        run(3'b001, 3'b100, 1, "s5_nsg2");
        check("s5_N_S", int'(N_S), 1);

        wait (rnd_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // 6: safety invariants under random stimulus on the short-green instance
    initial begin
        rst2_n = 1'b0; sens_ns2 = 2'b00; sens_lo2 = 2'b00; noturno2 = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (estado2 != PISCA) begin
                check("safe_both_go", int'(luz_ns2 != 3'b100 && luz_lo2 != 3'b100), 0);
                check("safe_onehot", int'($onehot(luz_ns2) && $onehot(luz_lo2)), 1);
            end
            sens_ns2 = 2'($urandom_range(0, 3));
            sens_lo2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) noturno2 = !noturno2;
            rst2_n = ($urandom_range(0, 799) != 0);
        end
        rnd_done = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
